// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// the controller state enum, the default memory depth and the request
// legality check used at accept time.
package dmem_ctrl_pkg;

  localparam int unsigned DMEM_WORDS_DEF = 2048;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_DONE
  } state_e;

  // A request is rejected for a reserved size, a misaligned halfword/word,
  // or a word index beyond the end of the attached memory.
  function automatic logic req_is_bad(input logic [1:0]  size,
                                      input logic [31:0] baddr,
                                      input int unsigned words);
    logic bad;
    bad = 1'b0;
    if (size == SZ_RSV)                           bad = 1'b1;
    if ((size == SZ_H) && baddr[0])               bad = 1'b1;
    if ((size == SZ_W) && (baddr[1:0] != 2'b00))  bad = 1'b1;
    if ({2'b00, baddr[31:2]} >= words)            bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ctrl_mem_lane.sv
// mem_lane: purely combinational byte-lane logic for the data-memory
// controller (little-endian lanes).
//   size_i     : access size (SZ_B / SZ_H / SZ_W)
//   signed_i   : sign-extend narrow loads when 1
//   offset_i   : byte address bits [1:0]
//   ld_word_i  : word read from memory, source of load extraction
//   rmw_word_i : word captured during the read half of a read-modify-write
//   wdata_i    : right-aligned store data
//   ld_data_o  : extracted and extended load result
//   st_word_o  : full word to write (merged for byte/half, wdata_i for word)
module mem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] ld_word_i,
  input  logic [31:0] rmw_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [4:0]  bit_base;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    bit_base  = {offset_i, 3'b000};
    ld_byte   = ld_word_i[bit_base +: 8];
    ld_half   = offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    ld_data_o = ld_word_i;
    case (size_i)
      SZ_B:    ld_data_o = signed_i ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      SZ_H:    ld_data_o = signed_i ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase

    // Only the addressed lane(s) take new data; the rest keep the read word.
    st_word_o = wdata_i;
    case (size_i)
      SZ_B: begin
        st_word_o = rmw_word_i;
        st_word_o[bit_base +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        st_word_o = rmw_word_i;
        if (offset_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else             st_word_o[15:0]  = wdata_i[15:0];
      end
      default: st_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller between a CPU pipeline
// and a synchronous-write / combinational-read word memory.
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata : request fields, captured on accept
//   resp_valid/resp_err/resp_rdata : one-cycle completion pulse and result
//   CS, DM_W, DM_R, addr, wdata, rdata : memory port (addr is a word index)
// Loads and word stores take one memory cycle; byte/halfword stores do a
// read-modify-write over two cycles. Rejected requests never touch memory.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        CS,
  output logic        DM_W,
  output logic        DM_R,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] res_q, res_d;
  logic [31:0] rmw_q, rmw_d;

  logic [31:0] ld_data;
  logic [31:0] st_word;

  mem_lane u_lane (
    .size_i     (size_q),
    .signed_i   (sgn_q),
    .offset_i   (addr_q[1:0]),
    .ld_word_i  (rdata),
    .rmw_word_i (rmw_q),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      res_q   <= 32'h0;
      rmw_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      res_q   <= res_d;
      rmw_q   <= rmw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    res_d   = res_q;
    rmw_d   = rmw_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_is_bad(req_size, req_addr, DMEM_WORDS);
          res_d   = 32'h0;
          if (err_d)              state_d = ST_DONE;
          else if (!req_we)       state_d = ST_LOAD;
          else if (req_size == SZ_W) state_d = ST_STORE;
          else                    state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        res_d   = ld_data;
        state_d = ST_DONE;
      end
      ST_STORE:  state_d = ST_DONE;
      ST_RMW_RD: begin
        rmw_d   = rdata;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Every outward strobe is gated by rst so a reset cycle can never write
  // memory or complete a response, even in the middle of an RMW.
  always_comb begin
    req_ready  = !rst && (state_q == ST_IDLE);
    DM_R       = !rst && ((state_q == ST_LOAD) || (state_q == ST_RMW_RD));
    DM_W       = !rst && ((state_q == ST_STORE) || (state_q == ST_RMW_WR));
    CS         = DM_R || DM_W;
    addr       = CS ? {2'b00, addr_q[31:2]} : 32'h0;
    wdata      = DM_W ? st_word : 32'h0;
    resp_valid = !rst && (state_q == ST_DONE);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !we_q && !err_q) ? res_q : 32'h0;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: behavioural memory, table of request vectors with
// a response scoreboard, plus hand-written reset-during-RMW and burst cases.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        CS, DM_W, DM_R;
  logic [31:0] addr, wdata, rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.DMEM_WORDS(2048)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .CS(CS), .DM_W(DM_W), .DM_R(DM_R),
    .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  logic [31:0] mem [0:2047];
  assign rdata = (CS && DM_R && addr < 32'd2048) ? mem[addr[10:0]] : 32'h0;
  always @(posedge clk) if (CS && DM_W && addr < 32'd2048) mem[addr[10:0]] <= wdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          cs_n;
    int          wr_off;
  } vec_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_log[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, cs_cnt = 0, dmw_cnt = 0, resp_cnt = 0, acc_cnt = 0;
  int   last_wr_cyc = 0, last_acc_cyc = 0, inv_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    cyc++;
    if (CS) cs_cnt++;
    if (CS && DM_W) begin
      dmw_cnt++;
      last_wr_cyc = cyc;
    end
    if ((!CS && (DM_R || DM_W || addr != 0 || wdata != 0)) ||
        (!resp_valid && resp_err) ||
        (rst && (CS || DM_R || DM_W || resp_valid || resp_err ||
                 addr != 0 || wdata != 0 || resp_rdata != 0)))
      inv_bad++;
    if (req_valid && req_ready && !rst) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
      last_acc_cyc = cyc;
      acc_cnt++;
    end
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_latency", 32'(cyc - a), 32'(e.lat));
      end
    end
  end

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    int   cs0, r0, to, dmw0, acc0, k, n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
    mem[5] <= 32'h11223344;
    mem[6] <= 32'h11223344;
    for (int i = 0; i < 6; i++) mem[8 + i] <= 32'hA5A50000 + 32'(i);

    //           we    size  sgn   addr         wdata          err   rdata          lat cs wr
    vecs[0]  = '{1'b1, SZ_W, 1'b0, 32'h10,      32'hDEADBEEF, 1'b0, 32'h0,        2, 1, 1};
    vecs[1]  = '{1'b0, SZ_W, 1'b0, 32'h10,      32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0};
    vecs[2]  = '{1'b1, SZ_B, 1'b0, 32'h12,      32'hAAAAAA55, 1'b0, 32'h0,        3, 2, 2};
    vecs[3]  = '{1'b0, SZ_W, 1'b0, 32'h10,      32'h0,        1'b0, 32'hDE55BEEF, 2, 1, 0};
    vecs[4]  = '{1'b0, SZ_B, 1'b1, 32'h13,      32'h0,        1'b0, 32'hFFFFFFDE, 2, 1, 0};
    vecs[5]  = '{1'b0, SZ_H, 1'b0, 32'h10,      32'h0,        1'b0, 32'h0000BEEF, 2, 1, 0};
    vecs[6]  = '{1'b0, SZ_H, 1'b1, 32'h10,      32'h0,        1'b0, 32'hFFFFBEEF, 2, 1, 0};
    vecs[7]  = '{1'b0, SZ_B, 1'b0, 32'h11,      32'h0,        1'b0, 32'h000000BE, 2, 1, 0};
    vecs[8]  = '{1'b0, SZ_B, 1'b1, 32'h12,      32'h0,        1'b0, 32'h00000055, 2, 1, 0};
    vecs[9]  = '{1'b1, SZ_H, 1'b0, 32'h16,      32'h12347777, 1'b0, 32'h0,        3, 2, 2};
    vecs[10] = '{1'b0, SZ_W, 1'b0, 32'h14,      32'h0,        1'b0, 32'h77773344, 2, 1, 0};
    vecs[11] = '{1'b0, SZ_H, 1'b0, 32'h16,      32'h0,        1'b0, 32'h00007777, 2, 1, 0};
    vecs[12] = '{1'b1, SZ_W, 1'b0, 32'h1FFC,    32'hCAFEF00D, 1'b0, 32'h0,        2, 1, 1};
    vecs[13] = '{1'b0, SZ_W, 1'b0, 32'h1FFC,    32'h0,        1'b0, 32'hCAFEF00D, 2, 1, 0};
    vecs[14] = '{1'b0, SZ_W, 1'b0, 32'h11,      32'h0,        1'b1, 32'h0,        1, 0, 0};
    vecs[15] = '{1'b0, SZ_H, 1'b0, 32'h13,      32'h0,        1'b1, 32'h0,        1, 0, 0};
    vecs[16] = '{1'b0, SZ_RSV, 1'b0, 32'h10,    32'h0,        1'b1, 32'h0,        1, 0, 0};
    vecs[17] = '{1'b0, SZ_W, 1'b0, 32'h2000,    32'h0,        1'b1, 32'h0,        1, 0, 0};
    vecs[18] = '{1'b1, SZ_B, 1'b0, 32'h2000,    32'h000000FF, 1'b1, 32'h0,        1, 0, 0};

    // Reset: a request presented during reset must not reach memory.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {31'h0, CS}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("post_rst_mem0", mem[0], 32'h0);
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      cs0 = cs_cnt; r0 = resp_cnt;
      req_we = v.we; req_size = v.size; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
      exp_q.push_back('{v.err, v.rdata, v.lat});
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      to = 0;
      while (resp_cnt == r0 && to < 10) begin
        @(posedge clk); #1;
        to++;
      end
      if (resp_cnt == r0) begin
        chk("resp_timeout", 32'(i), 32'hFFFFFFFF);
        exp_q.delete(); acc_q.delete();
      end
      chk("cs_cycles", 32'(cs_cnt - cs0), 32'(v.cs_n));
      if (v.wr_off != 0) chk("write_cycle", 32'(last_wr_cyc - last_acc_cyc), 32'(v.wr_off));
    end
    chk("mem_w4", mem[4], 32'hDE55BEEF);
    chk("mem_w5", mem[5], 32'h77773344);
    chk("mem_w2047", mem[2047], 32'hCAFEF00D);

    // Reset during the write half of a halfword RMW.
    dmw0 = dmw_cnt; r0 = resp_cnt; acc0 = acc_cnt;
    req_we = 1'b1; req_size = SZ_H; req_signed = 1'b0;
    req_addr = 32'h1A; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
    @(posedge clk); #1;          // RMW_RD
    req_valid = 1'b0;
    @(posedge clk); #1;          // RMW_WR
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_q.delete();
    @(negedge clk);
    chk("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("rmw_rst_accepted", 32'(acc_cnt - acc0), 32'd1);
    chk("rmw_rst_no_write", 32'(dmw_cnt - dmw0), 32'd0);
    chk("rmw_rst_mem", mem[6], 32'h11223344);
    chk("rmw_rst_no_resp", 32'(resp_cnt - r0), 32'd0);

    // Burst: req_valid held high across six word loads.
    r0 = resp_cnt; acc0 = acc_cnt;
    for (int i = 0; i < 6; i++) exp_q.push_back('{1'b0, 32'hA5A50000 + 32'(i), 2});
    req_we = 1'b0; req_size = SZ_W; req_addr = 32'h20; req_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      k = acc_cnt - acc0;
      if (k >= 6) break;
      req_addr = 32'h20 + 32'(4 * k);
    end
    req_valid = 1'b0;
    chk("burst_accepts", 32'(k), 32'd6);
    to = 0;
    while (resp_cnt - r0 < 6 && to < 20) begin
      @(posedge clk); #1;
      to++;
    end
    chk("burst_resps", 32'(resp_cnt - r0), 32'd6);
    n = acc_log.size();
    if (n >= 6) begin
      for (int j = 1; j < 6; j++)
        chk("burst_gap", 32'(acc_log[n - 6 + j] - acc_log[n - 7 + j]), 32'd3);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("interface_invariants", 32'(inv_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DMEM_WORDS, default 2048, number of 32-bit words in the attached data memory.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  pipeline requests a load/store this cycle.
REQ-005 req_ready  out  1  controller accepts a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_signed  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_err  out  1  valid with resp_valid; 1 = request rejected.
REQ-013 resp_rdata  out  32  load result, valid with resp_valid.
REQ-014 CS  out  1  memory chip select.
REQ-015 DM_W  out  1  memory write strobe; memory writes on posedge when CS & DM_W.
REQ-016 DM_R  out  1  memory read enable; memory read is combinational.
REQ-017 addr  out  32  memory word index (byte address >> 2).
REQ-018 wdata  out  32  memory write word.
REQ-019 rdata  in  32  memory read word; 0 when not CS & DM_R.

Function
REQ-020 States IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE; req_ready SHALL be 1 only in IDLE.
REQ-021 Accept (IDLE & req_valid) SHALL register we, size, signed, addr, wdata; cycle of accept is T.
REQ-022 Error if size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= DMEM_WORDS; errored request SHALL go to DONE, never assert CS, and respond at T+1 with resp_err=1, resp_rdata=0.
REQ-023 Load: LOAD at T+1 (CS=1, DM_R=1, DM_W=0), extracted result registered; resp_valid at T+2 from DONE.
REQ-024 Word store: STORE at T+1 (CS=1, DM_W=1, wdata=req_wdata); resp_valid at T+2.
REQ-025 Byte/half store: RMW_RD at T+1 (CS=1, DM_R=1) registers rdata; RMW_WR at T+2 (CS=1, DM_W=1) writes merged word; resp_valid at T+3.
REQ-026 Lanes little-endian: byte k = bits 8k+7:8k for addr[1:0]=k; halfword at addr[1]=h = bits 16h+15:16h.
REQ-027 Merge SHALL replace only the addressed lane(s) with low bits of req_wdata; other bytes SHALL equal the word read in RMW_RD.
REQ-028 DONE SHALL last exactly one cycle, pulse resp_valid, return to IDLE; a new request may be accepted the cycle after DONE (back-to-back throughput 1 per 3 cycles for loads/word stores).
REQ-029 Outside access states CS, DM_R, DM_W SHALL be 0; addr, wdata SHALL be 0 when CS=0.
REQ-030 resp_rdata SHALL be 0 for stores and errors; resp_err SHALL be 0 when resp_valid=0.
REQ-031 req_* inputs outside the accept cycle SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE on the next edge and clear all registered request and result state.
REQ-033 While rst=1, CS, DM_W, DM_R, resp_valid, resp_err SHALL be 0 combinationally (no memory write in a reset cycle, including mid-RMW); resp_rdata, addr, wdata SHALL be 0.
REQ-034 An operation interrupted by reset SHALL produce no resp_valid.

Structure
REQ-035 Shared package dmem_ctrl_pkg SHALL hold size encodings SZ_B/SZ_H/SZ_W, state enum, DMEM_WORDS default.
REQ-036 One combinational sub-module mem_lane SHALL perform load extraction/extension and store merge.

Verification
REQ-037 Word store 0xDEADBEEF at 0x10, then load word 0x10 -> memory word 4 written at T+1; load resp_rdata=0xDEADBEEF at T+2, resp_err=0.
REQ-038 With word 4=0xDEADBEEF, store byte 0x55 at 0x12 -> RMW read then write 0xDE55BEEF at T+2, resp_valid at T+3.
REQ-039 Load byte 0x13 signed from 0xDE55BEEF -> 0xFFFFFFDE; unsigned halfword 0x10 -> 0x0000BEEF.
REQ-040 Load word at 0x11, halfword at 0x13, size=11, word at 0x2000 -> resp_err=1 at T+1, CS never asserted.
REQ-041 Assert rst during RMW_WR of a halfword store -> no DM_W pulse, memory unchanged, no resp_valid, req_ready=1 next cycle.
REQ-042 req_valid held high for 6 word loads -> accepts every 3rd cycle, each resp_valid exactly once in order.
